action_input_conditioner: RTL
=============================

# action_input_conditioner

Conditions one player's six raw action push-buttons before the action converter in each player's input path. The six inputs are synchronised, debounced and edge-detected. One press at a time is latched as a one-hot action request, and the request is held until the downstream board logic acknowledges it on its game tick. One instance exists per player; its `act_out` feeds the 6-bit action input of the board top level.

## Interface
Parameters:
- `N_ACT`, default 6: number of action buttons; fixed at 6 for the board.
- `DB_CYCLES`, default 100000: number of consecutive stable `clk` cycles required to accept a new button level.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period in `clk` cycles. Used only when `ACT_REPEAT_EN` is defined.

Ports:
- `clk`, in, 1: system clock. The same undivided board clock feeds the frequency dividers.
- `rst`, in, 1: reset, asynchronous and active-low.
- `btn_in`, in, N_ACT: raw buttons, active-high, asynchronous to `clk`.
- `act_ack`, in, 1: single-cycle pulse in the `clk` domain. The consumer asserts it when it has taken the request.
- `act_out`, out, N_ACT: latched one-hot request. All zeros when no request is pending.
- `act_vld`, out, 1: high while `act_out` holds a request.
- `ovr`, out, 1: sticky flag. Set when a press is dropped; cleared only by reset.

## Operation
- **Synchroniser:** each bit passes through 2 flops, with reset value 0.
- **Debounce, per bit:**
  - Keeps a registered `stable` level and a counter.
  - When the synchronised level equals `stable`, the counter is 0.
  - Otherwise the counter increments each cycle.
  - When the counter equals `DB_CYCLES-1` and the levels still differ, `stable` takes the synchronised level and the counter returns to 0.
  - Any intermediate return to the `stable` level clears the counter.
  - Counter width is `$clog2(DB_CYCLES)`.
- **Edge detect:** `press[i] = stable[i] & ~stable_d[i]`. A release generates nothing.
- **FSM, states IDLE and PENDING:**
  - IDLE: if any `press` bit is set, `act_out` takes the lowest-index set bit (one-hot) and `act_vld` goes to 1. The FSM moves to PENDING. Other simultaneous presses are dropped and set `ovr`.
  - PENDING: `act_out` and `act_vld` are held. When `act_ack` is seen, `act_out` goes to 0, `act_vld` to 0, and the FSM returns to IDLE.
  - Any press arriving in PENDING is dropped and sets `ovr`, including a press in the same cycle as `act_ack`. In that case the ack wins and the press is lost.
  - `act_ack` in IDLE is ignored.
- **Reset:** reset asserted mid-operation clears everything immediately, whatever the state.
- **Reset values:**
  - `act_out`, `act_vld`, `ovr`: 0.
  - FSM state: IDLE.
  - All `stable`, synchroniser flops and counters: 0.
- **Held at reset:** a button held through reset release is seen as a press after debounce.

## Timing
- **Press latency:** `btn_in[i]` rises and stays high. First sampling edge is k. Then:
  - `stable[i]` is 1 after edge k+1+DB_CYCLES.
  - `act_vld` is 1 after edge k+2+DB_CYCLES.
- **Ack latency:** `act_ack` high at edge j gives `act_vld` = 0 after edge j. The earliest new request is accepted at edge j+1.
- **Glitches:** a glitch shorter than DB_CYCLES cycles never changes `stable`.
- **Outputs:** all outputs are registered, with no combinational path from inputs.

## Configuration
`ACT_REPEAT_EN`:
- **Defined:**
  - A repeat counter, width `$clog2(REPEAT_CYCLES)`, clears on every acceptance.
  - It increments each cycle while the last-accepted button's `stable` bit stays 1.
  - It clears when that bit goes to 0.
  - When it reaches `REPEAT_CYCLES-1` and the FSM is IDLE, the same one-hot action is re-issued as a new request and the counter clears.
  - If the FSM is PENDING at that point, the counter saturates until IDLE. The repeat issues on the first IDLE cycle and does not set `ovr`.
  - A fresh press edge in the same cycle takes priority over a repeat.
- **Not defined:** only press edges create requests, and no repeat logic is built.

## Structure
- **Package `act_pkg`:**
  - `N_ACT` localparam.
  - FSM state typedef (`ACT_IDLE`, `ACT_PENDING`).
  - Default `DB_CYCLES` and `REPEAT_CYCLES` values.
- **Sub-module `btn_debounce`:** one bit of synchroniser, debounce counter and `stable` register, with `stable` as its output.
  - Instantiated `N_ACT` times.
  - Edge detect, priority select, FSM and repeat logic live in the parent.

## Test plan
Use `DB_CYCLES=4` and `REPEAT_CYCLES=10`.
1. Raise `btn_in[2]` and hold it. Expect `act_vld`=1 and `act_out`=6'b000100 exactly 6 edges later. Pulse `act_ack` and expect `act_vld`=0 on the next edge with no re-issue (repeat disabled).
2. Pulse `btn_in[0]` high for 3 cycles. Expect `act_vld` to stay 0, `stable` never to change, and `ovr`=0.
3. Raise `btn_in[1]` and `btn_in[4]` in the same cycle. Expect `act_out`=6'b000010 and `ovr`=1.
4. While PENDING, raise `btn_in[3]` so that its press lands in the same cycle as `act_ack`. Expect `act_vld`=0 afterwards and `ovr`=1.
5. Assert `rst`=0 for 1 cycle while PENDING. Expect `act_out`=0, `act_vld`=0 and `ovr`=0 immediately, asynchronously.
6. With `ACT_REPEAT_EN`, hold `btn_in[5]` and ack each request 1 cycle after `act_vld`. Expect requests of 6'b100000 spaced 10 cycles apart. Release the button and expect no further requests.

Source files
------------

// File: rtl/act_pkg.sv
// act_pkg: shared constants and types for the per-player action input conditioner.
// Optional auto-repeat is enabled by defining ACT_REPEAT_EN at build time.
package act_pkg;

  // Number of action buttons per player on this board.
  localparam int unsigned N_ACT = 6;

  // Default debounce window: consecutive stable clk cycles before a new level is accepted.
  localparam int unsigned DB_CYCLES_DEF = 100000;

  // Default auto-repeat period in clk cycles.
  localparam int unsigned REPEAT_CYCLES_DEF = 25000000;

  // Request FSM states.
  typedef enum logic [0:0] {
    ACT_IDLE    = 1'b0,
    ACT_PENDING = 1'b1
  } act_state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one raw button bit -> two-flop synchroniser -> debounce counter -> stable level.
// The stable level only follows the synchronised input after it has disagreed with it for
// DB_CYCLES consecutive cycles; any return to the stable level restarts the count.
module btn_debounce
  import act_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/action_input_conditioner.sv
// action_input_conditioner: one player's six action buttons are synchronised, debounced and
// edge-detected; one press at a time is latched as a one-hot request held until act_ack.
// Simultaneous or overlapping presses are dropped and flagged on the sticky ovr output.
// Build option: define ACT_REPEAT_EN to re-issue a held button every REPEAT_CYCLES cycles.
module action_input_conditioner #(
  parameter int unsigned N_ACT         = act_pkg::N_ACT,
  parameter int unsigned DB_CYCLES     = act_pkg::DB_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = act_pkg::REPEAT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_ACT-1:0] btn_in,
  input  logic             act_ack,
  output logic [N_ACT-1:0] act_out,
  output logic             act_vld,
  output logic             ovr
);

  import act_pkg::*;

  logic [N_ACT-1:0] stable;
  logic [N_ACT-1:0] stable_dly_q;
  logic [N_ACT-1:0] press;
  logic [N_ACT-1:0] press_low;
  logic             press_any;
  logic             press_multi;
  logic             rpt_fire;
  logic [N_ACT-1:0] rpt_act;
  act_state_e       state_q;

  // Per-button synchroniser and debounce.
  for (genvar g = 0; g < N_ACT; g++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i   (clk),
      .rst_ni  (rst),
      .btn_i   (btn_in[g]),
      .stable_o(stable[g])
    );
  end

  // Delayed copy of the debounced levels for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_dly_q <= '0;
    end else begin
      stable_dly_q <= stable;
    end
  end

  // Only rising edges are presses; releases are ignored.
  assign press       = stable & ~stable_dly_q;
  assign press_any   = |press;
  // Isolate the lowest set bit; anything left over is a dropped simultaneous press.
  assign press_low   = press & (~press + N_ACT'(1));
  assign press_multi = |(press & ~press_low);

`ifdef ACT_REPEAT_EN

  localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RptMax = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0]    rpt_cnt_q;
  logic [N_ACT-1:0] last_q;
  logic             held;
  logic             accept;
  logic [N_ACT-1:0] accept_act;

  // The last accepted button is still held down (debounced level).
  assign held       = |(stable & last_q);
  assign rpt_fire   = (state_q == ACT_IDLE) && held && (rpt_cnt_q == RptMax);
  assign rpt_act    = last_q;
  assign accept     = (state_q == ACT_IDLE) && (press_any || rpt_fire);
  assign accept_act = press_any ? press_low : rpt_act;

  // Repeat timer: restarts on every acceptance, runs while held, saturates while pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q <= '0;
      last_q    <= '0;
    end else if (accept) begin
      rpt_cnt_q <= '0;
      last_q    <= accept_act;
    end else if (held) begin
      if (rpt_cnt_q != RptMax) begin
        rpt_cnt_q <= rpt_cnt_q + RW'(1);
      end
    end else begin
      rpt_cnt_q <= '0;
    end
  end

`else

  logic unused_repeat_cfg;

  assign rpt_fire          = 1'b0;
  assign rpt_act           = '0;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;

`endif

  // Request FSM with registered outputs; ack wins over a press landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACT_IDLE;
      act_out <= '0;
      act_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      case (state_q)
        ACT_IDLE: begin
          if (press_any) begin
            act_out <= press_low;
            act_vld <= 1'b1;
            state_q <= ACT_PENDING;
            if (press_multi) begin
              ovr <= 1'b1;
            end
          end else if (rpt_fire) begin
            act_out <= rpt_act;
            act_vld <= 1'b1;
            state_q <= ACT_PENDING;
          end
        end
        ACT_PENDING: begin
          if (press_any) begin
            ovr <= 1'b1;
          end
          if (act_ack) begin
            act_out <= '0;
            act_vld <= 1'b0;
            state_q <= ACT_IDLE;
          end
        end
        default: begin
          state_q <= ACT_IDLE;
          act_out <= '0;
          act_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
